// File: rtl/branch_resolve.sv
`default_nettype none
// ============================================================================
//  Module      : branch_resolve
//  Description : EX-stage branch resolution. Holds per-branch prediction
//                metadata from IF in a small FIFO, matches it against the
//                resolved outcome, drives predictor training strobes, the
//                misprediction flush/redirect and saturating statistics.
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_resolve #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_push,
  input  logic [31:0]      if_pc,
  input  logic             if_pred_T,
  input  logic             if_p1,
  input  logic             if_p2,
  input  logic [31:0]      if_target,
  output logic             if_full,
  input  logic             ex_resolve,
  input  logic [31:0]      ex_pc,
  input  logic             ex_T,
  input  logic [31:0]      ex_target,
  output logic             upd,
  output logic             upd_T,
  output logic [31:0]      upd_pc,
  output logic             p1_cor,
  output logic             p2_cor,
  output logic             flush,
  output logic [31:0]      redirect_pc,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] mp_count
);

  localparam int c_AW = $clog2(DEPTH);
  localparam logic [c_AW:0]    c_PTR_ONE = {{c_AW{1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // FIFO storage and pointers (extra MSB distinguishes full from empty)
  logic [31:0] r_mem_pc  [DEPTH];
  logic [31:0] r_mem_tgt [DEPTH];
  logic        r_mem_t   [DEPTH];
  logic        r_mem_p1  [DEPTH];
  logic        r_mem_p2  [DEPTH];
  logic [c_AW:0] r_rd_ptr;
  logic [c_AW:0] r_wr_ptr;

  // Registered outputs
  logic             r_upd;
  logic             r_upd_T;
  logic [31:0]      r_upd_pc;
  logic             r_p1_cor;
  logic             r_p2_cor;
  logic             r_flush;
  logic [31:0]      r_redirect_pc;
  logic [CNT_W-1:0] r_br_count;
  logic [CNT_W-1:0] r_mp_count;

  logic        w_empty;
  logic        w_full;
  logic        w_resolve;
  logic        w_pop;
  logic        w_push;
  logic        w_hit;
  logic        w_mispred;
  logic [31:0] w_head_pc;
  logic [31:0] w_head_tgt;
  logic        w_head_t;
  logic        w_head_p1;
  logic        w_head_p2;

  // Queue status, head entry and the resolve comparison
  always_comb begin
    w_empty    = (r_rd_ptr == r_wr_ptr);
    w_full     = (r_rd_ptr[c_AW] != r_wr_ptr[c_AW]) &&
                 (r_rd_ptr[c_AW-1:0] == r_wr_ptr[c_AW-1:0]);
    // A resolve arriving in a flush cycle belongs to a squashed instruction
    w_resolve  = ex_resolve && !r_flush;
    w_pop      = w_resolve && !w_empty;
    // A pop in the same cycle frees a slot, so a full queue can still accept
    w_push     = if_push && !r_flush && (!w_full || w_pop);
    w_head_pc  = r_mem_pc [r_rd_ptr[c_AW-1:0]];
    w_head_tgt = r_mem_tgt[r_rd_ptr[c_AW-1:0]];
    w_head_t   = r_mem_t  [r_rd_ptr[c_AW-1:0]];
    w_head_p1  = r_mem_p1 [r_rd_ptr[c_AW-1:0]];
    w_head_p2  = r_mem_p2 [r_rd_ptr[c_AW-1:0]];
    w_hit      = !w_empty && (w_head_pc == ex_pc);
    w_mispred  = !w_hit || (w_head_t != ex_T) || (ex_T && (w_head_tgt != ex_target));
  end

  // Metadata storage; contents are only meaningful between the pointers
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_pc [r_wr_ptr[c_AW-1:0]] <= if_pc;
      r_mem_tgt[r_wr_ptr[c_AW-1:0]] <= if_target;
      r_mem_t  [r_wr_ptr[c_AW-1:0]] <= if_pred_T;
      r_mem_p1 [r_wr_ptr[c_AW-1:0]] <= if_p1;
      r_mem_p2 [r_wr_ptr[c_AW-1:0]] <= if_p2;
    end
  end

  // Pointer update; a flush discards every in-flight entry
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
    end else if (r_flush) begin
      r_rd_ptr <= r_wr_ptr;
    end else begin
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
    end
  end

  // Training strobes and redirect, registered one cycle after resolve
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_upd         <= 1'b0;
      r_upd_T       <= 1'b0;
      r_upd_pc      <= '0;
      r_p1_cor      <= 1'b0;
      r_p2_cor      <= 1'b0;
      r_flush       <= 1'b0;
      r_redirect_pc <= '0;
    end else begin
      r_upd    <= w_resolve;
      r_p1_cor <= w_resolve && w_hit && (w_head_p1 == ex_T);
      r_p2_cor <= w_resolve && w_hit && (w_head_p2 == ex_T);
      r_flush  <= w_resolve && w_mispred;
      if (w_resolve) begin
        r_upd_T       <= ex_T;
        r_upd_pc      <= ex_pc;
        r_redirect_pc <= ex_T ? ex_target : (ex_pc + 32'd4);
      end
    end
  end

  // Saturating statistics, updated on the same edge as the strobes
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_br_count <= '0;
      r_mp_count <= '0;
    end else if (w_resolve) begin
      if (r_br_count != '1) r_br_count <= r_br_count + c_CNT_ONE;
      if (w_mispred && (r_mp_count != '1)) r_mp_count <= r_mp_count + c_CNT_ONE;
    end
  end

  assign if_full     = w_full;
  assign upd         = r_upd;
  assign upd_T       = r_upd_T;
  assign upd_pc      = r_upd_pc;
  assign p1_cor      = r_p1_cor;
  assign p2_cor      = r_p2_cor;
  assign flush       = r_flush;
  assign redirect_pc = r_redirect_pc;
  assign br_count    = r_br_count;
  assign mp_count    = r_mp_count;

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve.sv
`default_nettype none
// ============================================================================
//  Module      : tb_branch_resolve
//  Description : Scoreboard bench for branch_resolve (DEPTH=4, CNT_W=4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_resolve;
  localparam int DEPTH = 4;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic if_push = 1'b0, if_pred_T = 1'b0, if_p1 = 1'b0, if_p2 = 1'b0;
  logic [31:0] if_pc = '0, if_target = '0;
  logic ex_resolve = 1'b0, ex_T = 1'b0;
  logic [31:0] ex_pc = '0, ex_target = '0;
  logic if_full, upd, upd_T, p1_cor, p2_cor, flush;
  logic [31:0] upd_pc, redirect_pc;
  logic [CNT_W-1:0] br_count, mp_count;

  branch_resolve #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .if_push(if_push), .if_pc(if_pc), .if_pred_T(if_pred_T), .if_p1(if_p1),
    .if_p2(if_p2), .if_target(if_target), .if_full(if_full),
    .ex_resolve(ex_resolve), .ex_pc(ex_pc), .ex_T(ex_T), .ex_target(ex_target),
    .upd(upd), .upd_T(upd_T), .upd_pc(upd_pc), .p1_cor(p1_cor), .p2_cor(p2_cor),
    .flush(flush), .redirect_pc(redirect_pc), .br_count(br_count), .mp_count(mp_count)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] pc; logic t; logic p1; logic p2; logic [31:0] tgt; } ent_t;
  typedef struct { logic t; logic [31:0] pc; logic p1c; logic p2c; logic fl; logic [31:0] rpc; } exp_t;

  ent_t mq[$];     // reference queue of in-flight branches
  exp_t exq[$];    // scoreboard of expected training responses
  bit   m_flush;   // a flush is expected to be visible this cycle
  int   n_br, n_mp;
  int   checks = 0;
  int   errors = 0;

  function automatic int sat(input int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: apply this cycle's inputs at the clock edge
  task automatic model_step();
    bit eff, pop, push, hit, mp, nflush;
    exp_t e;
    ent_t n;
    eff  = ex_resolve && !m_flush;
    pop  = eff && (mq.size() != 0);
    push = if_push && !m_flush && ((mq.size() < DEPTH) || pop);
    nflush = 1'b0;
    if (eff) begin
      hit = (mq.size() != 0) && (mq[0].pc == ex_pc);
      if (hit) mp = (mq[0].t != ex_T) || (ex_T && (mq[0].tgt != ex_target));
      else     mp = 1'b1;
      e.t   = ex_T;
      e.pc  = ex_pc;
      e.p1c = hit && (mq[0].p1 == ex_T);
      e.p2c = hit && (mq[0].p2 == ex_T);
      e.fl  = mp;
      e.rpc = ex_T ? ex_target : ex_pc + 32'd4;
      exq.push_back(e);
      n_br++;
      if (mp) n_mp++;
      nflush = mp;
    end
    if (m_flush) mq.delete();
    else begin
      if (pop) void'(mq.pop_front());
      if (push) begin
        n.pc = if_pc; n.t = if_pred_T; n.p1 = if_p1; n.p2 = if_p2; n.tgt = if_target;
        mq.push_back(n);
      end
    end
    m_flush = nflush;
  endtask

  task automatic cycle(input bit psh, input logic [31:0] pc, input bit pt, input bit p1,
                       input bit p2, input logic [31:0] tgt, input bit res,
                       input logic [31:0] epc, input bit et, input logic [31:0] etgt);
    @(negedge clk);
    if_push = psh; if_pc = pc; if_pred_T = pt; if_p1 = p1; if_p2 = p2; if_target = tgt;
    ex_resolve = res; ex_pc = epc; ex_T = et; ex_target = etgt;
    @(posedge clk);
    model_step();
  endtask

  task automatic idle();
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Asynchronous reset between edges; outputs must clear immediately
  task automatic do_reset();
    @(negedge clk);
    if_push = 0; ex_resolve = 0;
    #2 rst = 1'b0;
    #1;
    chk("rst_full", {31'd0, if_full}, 0);
    chk("rst_upd", {31'd0, upd}, 0);
    chk("rst_flush", {31'd0, flush}, 0);
    chk("rst_cor", {30'd0, p1_cor, p2_cor}, 0);
    chk("rst_upd_pc", upd_pc, 0);
    chk("rst_redirect", redirect_pc, 0);
    chk("rst_br", {28'd0, br_count}, 0);
    chk("rst_mp", {28'd0, mp_count}, 0);
    mq.delete(); exq.delete(); m_flush = 0; n_br = 0; n_mp = 0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Monitor: compare DUT responses against the scoreboard
  always @(negedge clk) begin
    if (rst) begin
      chk("if_full", {31'd0, if_full}, {31'd0, mq.size() == DEPTH});
      if (upd) begin
        if (exq.size() == 0) chk("unexpected_upd", {31'd0, upd}, 0);
        else begin
          exp_t e;
          e = exq.pop_front();
          chk("upd_T", {31'd0, upd_T}, {31'd0, e.t});
          chk("upd_pc", upd_pc, e.pc);
          chk("p1_cor", {31'd0, p1_cor}, {31'd0, e.p1c});
          chk("p2_cor", {31'd0, p2_cor}, {31'd0, e.p2c});
          chk("flush", {31'd0, flush}, {31'd0, e.fl});
          if (e.fl) chk("redirect_pc", redirect_pc, e.rpc);
        end
      end else begin
        chk("idle_strobes", {29'd0, flush, p1_cor, p2_cor}, 0);
        if (exq.size() != 0) begin
          chk("missing_upd", {31'd0, upd}, 1);
          exq.delete();
        end
      end
      chk("br_count", {28'd0, br_count}, sat(n_br));
      chk("mp_count", {28'd0, mp_count}, sat(n_mp));
    end
  end

  initial begin
    logic [31:0] pc, epc, etgt;
    bit hitsel;
    m_flush = 0; n_br = 0; n_mp = 0;
    #1;
    chk("init_full", {31'd0, if_full}, 0);
    chk("init_upd", {31'd0, upd}, 0);
    chk("init_br", {28'd0, br_count}, 0);
    @(negedge clk);
    rst = 1'b1;

    // Correct prediction
    cycle(1, 32'h100, 1, 1, 0, 32'h200, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 1, 32'h100, 1, 32'h200);
    idle();
    // Direction mispredict; push during flush is dropped
    cycle(1, 32'h100, 1, 1, 0, 32'h200, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 1, 32'h100, 0, 32'h200);
    cycle(1, 32'h180, 0, 0, 0, 32'h0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 1, 32'h180, 0, 32'h0);
    idle(); idle();
    // Fill, overflow push, then push+resolve at full across pointer wrap
    for (int i = 0; i < 5; i++)
      cycle(1, 32'h1000 + 32'(i * 16), i[0], i[1], i[0], 32'h2000 + 32'(i), 0, 0, 0, 0);
    for (int i = 0; i < 8; i++)
      cycle(1, 32'h3000 + 32'(i * 16), 0, 1, 0, 0, 1, mq[0].pc, mq[0].t, mq[0].tgt);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 0, 0, 1, mq[0].pc, mq[0].t, mq[0].tgt);
    idle();
    // Empty-queue resolve and PC mismatch
    cycle(0, 0, 0, 0, 0, 0, 1, 32'h440, 1, 32'h880);
    idle();
    cycle(1, 32'h500, 0, 1, 1, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 1, 32'h504, 0, 32'h999);
    idle();
    // Target mispredict with correct direction
    cycle(1, 32'h600, 1, 1, 0, 32'h300, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 1, 32'h600, 1, 32'h304);
    idle();
    // Reset with three entries in flight, then counter saturation
    for (int i = 0; i < 3; i++) cycle(1, 32'h700 + 32'(i * 4), 1, 1, 1, 32'h10, 0, 0, 0, 0);
    do_reset();
    for (int i = 0; i < 17; i++) begin
      cycle(0, 0, 0, 0, 0, 0, 1, 32'h800 + 32'(i * 4), 0, 0);
      idle();
    end
    do_reset();

    // Randomized traffic
    for (int i = 0; i < 1200; i++) begin
      if (i % 300 == 299) do_reset();
      pc = $urandom & 32'hFFFF_FFFC;
      hitsel = (mq.size() != 0) && ($urandom_range(3) != 0);
      epc  = hitsel ? mq[0].pc : ($urandom & 32'hFFFF_FFFC);
      etgt = (hitsel && $urandom_range(3) != 0) ? mq[0].tgt : $urandom;
      cycle($urandom_range(1), pc, $urandom_range(1), $urandom_range(1), $urandom_range(1),
            $urandom, $urandom_range(2) == 0, epc,
            hitsel && ($urandom_range(3) != 0) ? mq[0].t : 1'($urandom_range(1)), etgt);
    end
    idle(); idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
